// File: rtl/fb_ahb_slave_pkg.sv
// Shared frame-buffer geometry, default window placement and the write-queue entry type
// for the GPU pixel-bus frame-buffer responder.
package gpu_fb_pkg;

  localparam int FB_WIDTH     = 320;
  localparam int FB_HEIGHT    = 240;
  localparam int FB_BUFFERS   = 2;
  localparam int FB_WORDS_DEF = FB_WIDTH * FB_HEIGHT * FB_BUFFERS;
  localparam int FB_MEM_AW    = 18;

  localparam logic [31:0] FB_BASE_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [FB_MEM_AW-1:0] addr;
    logic [31:0]          data;
  } fb_wr_t;

  // Byte address falls inside the word window [base, base + 4*words).
  function automatic logic in_window(input logic [31:0] haddr,
                                     input logic [31:0] base,
                                     input logic [31:0] words);
    return (haddr >= base) && (((haddr - base) >> 2) < words);
  endfunction

endpackage

// File: rtl/fb_ahb_slave_if.sv
// AHB-lite write-only bus between the GPU master and the frame-buffer responder.
interface fb_ahb_slave_if;

  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;

  modport master (output HADDR, output HWRITE, output HWDATA, input HREADY);
  modport slave  (input HADDR, input HWRITE, input HWDATA, output HREADY);

endinterface

// File: rtl/fb_ahb_slave_wr_fifo.sv
// Write queue between the bus data phase and the frame-buffer memory port; occupancy is
// tracked with read/write pointers carrying one extra wrap bit.
module fb_wr_fifo
  import gpu_fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  fb_wr_t din,
  input  logic   pop,
  output fb_wr_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  fb_wr_t      mem_q [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Empty queue presents zeros so the memory port never shows stale or unwritten storage.
  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fb_ahb_slave.sv
// AHB-lite single-beat pixel write responder: range-checks addresses, queues in-range
// writes, drains them to the frame-buffer memory port and reports idle/error status.
module fb_ahb_slave
  import gpu_fb_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = FB_BASE_ADDR,
  parameter logic [31:0] FB_WORDS  = 32'(FB_WORDS_DEF),
  parameter int          MEM_AW    = FB_MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  fb_ahb_slave_if.slave     bus,
  output logic              mem_wr_en,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              idle,
  output logic [15:0]       wr_count,
  output logic [7:0]        err_count
);

  logic              pend_valid_q, pend_valid_d;
  logic              pend_inrange_q, pend_inrange_d;
  logic [MEM_AW-1:0] pend_off_q, pend_off_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [7:0]        err_count_q, err_count_d;

  logic   hready, push, drop, pop;
  logic   fifo_full, fifo_empty;
  fb_wr_t push_entry, head_entry;

  // Only an in-range write facing a full queue can stall; HREADY is purely registered state.
  assign hready = ~(pend_valid_q & pend_inrange_q & fifo_full);
  assign push   = hready & pend_valid_q & pend_inrange_q;
  assign drop   = hready & pend_valid_q & ~pend_inrange_q;
  assign pop    = ~fifo_empty & mem_ready;

  always_comb begin
    pend_valid_d   = pend_valid_q;
    pend_inrange_d = pend_inrange_q;
    pend_off_d     = pend_off_q;
    if (hready) begin
      pend_valid_d = bus.HWRITE;
      if (bus.HWRITE) begin
        pend_inrange_d = in_window(bus.HADDR, BASE_ADDR, FB_WORDS);
        pend_off_d     = MEM_AW'((bus.HADDR - BASE_ADDR) >> 2);
      end
    end
  end

  always_comb begin
    wr_count_d  = wr_count_q + {15'd0, push};
    err_count_d = err_count_q;
    if (drop && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_comb begin
    push_entry      = '0;
    push_entry.addr = FB_MEM_AW'(pend_off_q);
    push_entry.data = bus.HWDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q   <= 1'b0;
      pend_inrange_q <= 1'b0;
      pend_off_q     <= '0;
      wr_count_q     <= '0;
      err_count_q    <= '0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_inrange_q <= pend_inrange_d;
      pend_off_q     <= pend_off_d;
      wr_count_q     <= wr_count_d;
      err_count_q    <= err_count_d;
    end
  end

  fb_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.HREADY = hready;
  assign mem_wr_en  = ~fifo_empty;
  assign mem_addr   = MEM_AW'(head_entry.addr);
  assign mem_wdata  = head_entry.data;
  assign idle       = fifo_empty & ~pend_valid_q;
  assign wr_count   = wr_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_fb_ahb_slave.sv
// Self-checking bench for fb_ahb_slave: a queue-based transaction model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fb_ahb_slave;

  localparam int          DEPTH  = 4;
  localparam int          MEM_AW = 18;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam longint      WORDS  = 153600;
  localparam logic [31:0] OOR    = 32'h0009_6000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_ready = 1'b0;
  logic              mem_wr_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              idle;
  logic [15:0]       wr_count;
  logic [7:0]        err_count;

  fb_ahb_slave_if bus ();

  fb_ahb_slave #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .FB_WORDS  (32'd153600),
    .MEM_AW    (MEM_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .idle      (idle),
    .wr_count  (wr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    int unsigned a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  bit          m_pv  = 0;
  bit          m_pin = 0;
  int unsigned m_off = 0;
  int unsigned m_wr  = 0;
  int unsigned m_err = 0;
  bit          m_hr;
  longint      m_rel;
  ent_t        m_e;

  function automatic bit m_hready();
    return !(m_pv && m_pin && (m_q.size() == DEPTH));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pv  = 0;
      m_pin = 0;
      m_wr  = 0;
      m_err = 0;
    end else begin
      m_hr = m_hready();
      if ((m_q.size() != 0) && mem_ready) void'(m_q.pop_front());
      if (m_hr && m_pv) begin
        if (m_pin) begin
          m_e.a = m_off;
          m_e.d = bus.HWDATA;
          m_q.push_back(m_e);
          m_wr = (m_wr + 1) % 65536;
        end else if (m_err < 255) begin
          m_err++;
        end
      end
      if (m_hr) begin
        m_pv = bus.HWRITE;
        if (bus.HWRITE) begin
          m_rel = longint'(bus.HADDR) - longint'(BASE);
          m_pin = (m_rel >= 0) && ((m_rel / 4) < WORDS);
          m_off = int'((m_rel / 4) % (64'd1 << MEM_AW));
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check("hready", bus.HREADY, m_hready());
    check("mem_wr_en", mem_wr_en, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("mem_addr", mem_addr, m_q[0].a);
      check("mem_wdata", mem_wdata, m_q[0].d);
    end
    check("idle", idle, (m_q.size() == 0) && !m_pv);
    check("wr_count", wr_count, m_wr);
    check("err_count", err_count, m_err);
  end

  // Memory-side log and stall counter.
  int unsigned log_a[$];
  logic [31:0] log_d[$];
  int          stall_cnt = 0;

  always @(negedge clk) begin
    if (!rst && mem_wr_en && mem_ready) begin
      log_a.push_back(int'(mem_addr));
      log_d.push_back(mem_wdata);
    end
    if (!rst && !bus.HREADY) stall_cnt++;
  end

  // ---------------- bus driver ----------------
  logic [31:0] next_wd = '0;

  task automatic step(input logic hw, input logic [31:0] a, input logic [31:0] d);
    int waited;
    waited     = 0;
    bus.HWRITE = hw;
    bus.HADDR  = a;
    bus.HWDATA = d;
    @(negedge clk);
    while (!bus.HREADY && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.HREADY) check("step_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic hw, input logic [31:0] a, input logic [31:0] d);
    step(hw, a, next_wd);
    next_wd = d;
  endtask

  task automatic flush();
    xfer(1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    bus.HWRITE = 1'b0;
    rst        = 1'b1;
    next_wd    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_a.delete();
    log_d.delete();
  endtask

  task automatic drain();
    int waited;
    waited    = 0;
    mem_ready = 1'b1;
    @(negedge clk);
    while (!idle && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("drain_idle", idle, 1'b1);
    @(posedge clk);
    #1;
  endtask

  int s0;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.HWRITE = 1'b0;
    bus.HADDR  = '0;
    bus.HWDATA = '0;
    #3;
    check("rst_hready", bus.HREADY, 1'b1);
    check("rst_mem_wr_en", mem_wr_en, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_idle", idle, 1'b1);
    check("rst_wr_count", wr_count, 0);
    check("rst_err_count", err_count, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Single write: presented two cycles after its address phase.
    mem_ready = 1'b1;
    xfer(1'b1, 32'h0000_0010, 32'h00FF_00FF);
    flush();
    @(negedge clk);
    check("single_wr_en", mem_wr_en, 1'b1);
    check("single_addr", mem_addr, 4);
    check("single_data", mem_wdata, 32'h00FF_00FF);
    check("single_wr_count", wr_count, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_idle", idle, 1'b1);
    @(posedge clk);
    #1;

    // Back-pressure: memory stalled, 6 back-to-back writes.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) xfer(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i));
    s0 = stall_cnt;
    fork
      xfer(1'b1, 32'd20, 32'hA000_0005);
      begin
        @(negedge clk);
        check("bp_stall_a", bus.HREADY, 1'b0);
        check("bp_head", mem_addr, 0);
        repeat (2) @(negedge clk);
        check("bp_stall_b", bus.HREADY, 1'b0);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
      end
    join
    check("bp_stall_cycles", 64'(stall_cnt - s0), 4);
    flush();
    drain();
    check("bp_log_size", log_a.size(), 6);
    for (int i = 0; i < 6 && i < log_a.size(); i++) begin
      check("bp_log_addr", log_a[i], i);
      check("bp_log_data", log_d[i], 32'hA000_0000 + 32'(i));
    end
    check("bp_wr_count", wr_count, 6);

    // Out of range with the queue full: never stalls, error count saturates.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) xfer(1'b1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    s0 = stall_cnt;
    xfer(1'b1, OOR, 32'hDEAD_0000);
    xfer(1'b1, OOR, 32'hDEAD_0001);
    @(negedge clk);
    check("oor_err_1", err_count, 1);
    check("oor_full_wr", wr_count, 4);
    @(posedge clk);
    #1;
    for (int i = 0; i < 298; i++) xfer(1'b1, OOR, 32'hDEAD_1000 + 32'(i));
    flush();
    check("oor_no_stall", 64'(stall_cnt - s0), 0);
    check("oor_err_sat", err_count, 255);
    check("oor_wr_count", wr_count, 4);
    drain();
    check("oor_log_size", log_a.size(), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) check("oor_log_addr", log_a[i], 64 + i);

    // Simultaneous push/pop at DEPTH-1 occupancy.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) xfer(1'b1, 32'h400 + 32'(4 * i), 32'hC000_0000 + 32'(i));
    mem_ready = 1'b1;
    s0 = stall_cnt;
    for (int i = 4; i < 23; i++) xfer(1'b1, 32'h400 + 32'(4 * i), 32'hC000_0000 + 32'(i));
    flush();
    check("pp_no_stall", 64'(stall_cnt - s0), 0);
    drain();
    check("pp_log_size", log_a.size(), 23);
    for (int i = 0; i < 23 && i < log_a.size(); i++) begin
      check("pp_log_addr", log_a[i], 256 + i);
      check("pp_log_data", log_d[i], 32'hC000_0000 + 32'(i));
    end
    check("pp_wr_count", wr_count, 23);

    // Idle cycles interleaved with writes, low-bit and window-edge addresses.
    do_reset();
    mem_ready = 1'b1;
    xfer(1'b1, 32'h0000_0000, 32'hD000_0000);
    xfer(1'b0, 32'h0000_0044, 32'h0);
    xfer(1'b1, 32'h0000_0013, 32'hD000_0001);
    xfer(1'b0, 32'h0000_0020, 32'h0);
    xfer(1'b0, 32'h0000_0024, 32'h0);
    xfer(1'b1, 32'h0009_5FFC, 32'hD000_0002);
    xfer(1'b1, OOR, 32'hD000_0003);
    xfer(1'b0, 32'h0000_0000, 32'h0);
    xfer(1'b1, 32'h0000_0008, 32'hD000_0004);
    xfer(1'b1, 32'h0000_000C, 32'hD000_0005);
    flush();
    drain();
    check("il_wr_count", wr_count, 5);
    check("il_err_count", err_count, 1);
    check("il_log_size", log_a.size(), 5);
    if (log_a.size() == 5) begin
      check("il_a0", log_a[0], 0);
      check("il_a1", log_a[1], 4);
      check("il_a2", log_a[2], 153599);
      check("il_a3", log_a[3], 2);
      check("il_a4", log_a[4], 3);
      check("il_d2", log_d[2], 32'hD000_0002);
      check("il_d4", log_d[4], 32'hD000_0005);
    end

    // Asynchronous reset in the middle of a stall with a full queue.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) xfer(1'b1, 32'(4 * i), 32'hE000_0000 + 32'(i));
    bus.HWRITE = 1'b1;
    bus.HADDR  = 32'd20;
    bus.HWDATA = next_wd;
    @(negedge clk);
    check("mid_pre_stall", bus.HREADY, 1'b0);
    check("mid_pre_wr", wr_count, 4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_hready", bus.HREADY, 1'b1);
    check("mid_mem_wr_en", mem_wr_en, 1'b0);
    check("mid_idle", idle, 1'b1);
    check("mid_wr_count", wr_count, 0);
    check("mid_err_count", err_count, 0);
    bus.HWRITE = 1'b0;
    next_wd    = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    log_a.delete();
    log_d.delete();
    mem_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_no_stale", log_a.size(), 0);
    check("mid_after_wr_en", mem_wr_en, 1'b0);
    check("mid_after_wr", wr_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_ahb_slave.md
Name: fb_ahb_slave

Overview:
AHB-lite write responder on the frame-buffer side of the GPU pixel bus. It accepts single-beat pixel writes from the GPU AHB master and queues them in a small write FIFO. It drains the FIFO to a simple SRAM-style frame-buffer port and applies back-pressure through HREADY. It also range-checks addresses and reports idle and error status, which the system uses to gate buffer flips.

Parameters:
DEPTH, 4, write FIFO entries (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte base address of frame-buffer window
FB_WORDS, 153600, window size in 32-bit words (two 320x240 buffers)
MEM_AW, 18, memory word-address width (2**MEM_AW >= FB_WORDS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
HADDR  in  32  byte address, address phase
HWRITE  in  1  write request, address phase; the bus has no HTRANS, so HWRITE=1 marks a valid transfer
HWDATA  in  32  pixel color, data phase
HREADY  out  1  1 = current data phase completes this cycle
mem_wr_en  out  1  FIFO head valid, write request to frame-buffer memory
mem_addr  out  MEM_AW  word address of head entry
mem_wdata  out  32  color of head entry
mem_ready  in  1  memory accepts head entry this cycle
idle  out  1  FIFO empty and no data phase pending
wr_count  out  16  accepted in-range writes, wraps at 2**16
err_count  out  8  dropped out-of-range writes, saturates at 255

Behaviour:
- Reset: async on rst high, clears all state.
  - HREADY=1, mem_wr_en=0, mem_addr=0, mem_wdata=0, idle=1, wr_count=0, err_count=0.
  - FIFO contents and any pending transfer are discarded, including mid-stall.
- Address phase: on a clk edge with HREADY=1 and HWRITE=1:
  - register pend_valid=1, pend_addr=HADDR.
  - register pend_inrange = (HADDR >= BASE_ADDR) && (((HADDR-BASE_ADDR)>>2) < FB_WORDS).
  - HADDR[1:0] is ignored.
- On a clk edge with HREADY=1 and HWRITE=0: pend_valid<=0.
- Data phase: the cycle after the address phase, with pend_valid=1.
- HREADY = ~(pend_valid & pend_inrange & fifo_full). It depends only on registered state; there is no combinational path from mem_ready or any bus input.
- Data phase completion, on a clk edge with HREADY=1 and pend_valid=1:
  - In range: push {(pend_addr-BASE_ADDR)>>2 truncated to MEM_AW, HWDATA}; wr_count++.
  - Out of range: drop the data; err_count++ (saturating); never stalls.
- Stall: while HREADY=0 the master holds HADDR/HWRITE/HWDATA. The pend_* registers are held. A pop that frees a slot raises HREADY on the following cycle, so at most one extra stall cycle.
- Pipelining: back-to-back writes sustain 1 per cycle while the FIFO is not full. The data phase of write N overlaps the address phase of write N+1.
- Drain:
  - mem_wr_en = ~fifo_empty; mem_addr/mem_wdata = head entry (registered storage).
  - Pop on a clk edge with mem_wr_en & mem_ready.
  - With mem_ready held 1: address phase at cycle N, data phase at N+1, entry presented on the memory port at N+2, written at the end of N+2.
- Simultaneous push and pop: allowed at any occupancy except push when full, which HREADY prevents. Count is unchanged; pointers both advance and wrap modulo DEPTH.
- Ordering: strict FIFO; memory write order equals bus order.
- idle = fifo_empty & ~pend_valid, registered-state only.

Decomposition:
- Package gpu_fb_pkg:
  - FB_WIDTH=320, FB_HEIGHT=240, FB_BUFFERS=2.
  - BASE_ADDR default.
  - typedef fb_wr_t {logic [MEM_AW-1:0] addr; logic [31:0] data;}.
- Sub-module fb_wr_fifo: synchronous FIFO with push/pop, full/empty, head data, and a pointer-plus-extra-bit occupancy scheme.
- fb_ahb_slave contains the address-phase registers, range check, HREADY logic and counters.

Test Plan:
- Reset: assert rst mid-stall with 4 entries queued -> HREADY=1, mem_wr_en=0, idle=1, counters 0 immediately (asynchronous), and no stale write appears after release.
- Single write: HADDR=0x0000_0010, HWDATA=0x00FF00FF, mem_ready=1 -> mem_wr_en=1 with mem_addr=4, mem_wdata=0x00FF00FF two cycles after the address phase; wr_count=1; idle=1 after the pop.
- Back-pressure: mem_ready=0, 6 back-to-back writes to addresses 0,4,...,20 -> HREADY drops during the 5th data phase and the 6th address is held. Raise mem_ready -> memory receives word addresses 0..5 in order; wr_count=6.
- Out of range: HADDR=BASE_ADDR+4*FB_WORDS with FIFO full -> no stall, no push, err_count=1. Then 300 such writes -> err_count=255.
- Simultaneous push/pop at DEPTH-1 occupancy with mem_ready=1 -> HREADY stays 1 and sustains 1 write/cycle for 20 writes; all 20 writes appear in order.
- HWRITE=0 idle cycles interleaved with writes -> no spurious pushes; wr_count equals the number of HWRITE=1 address phases.
